// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int REG_W   = 32;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 2;
    localparam int AGE_MAX = 3;

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int AGE_W  = 2;
    localparam int PEND_W = (1 << ADDR_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] wn;
        logic [REG_W-1:0]  wd;
    } wbuf_entry_t;

    // One-hot scoreboard mask for a register; r0 maps to an empty mask.
    function automatic logic [PEND_W-1:0] reg_bit(input logic [ADDR_W-1:0] addr);
        reg_bit = '0;
        if (addr != '0) begin
            reg_bit[addr - ADDR_W'(1)] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/rf_wbuf.sv
// Small FIFO holding multi-cycle results until the write port is free.
module rf_wbuf
    import rf_arb_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              push,
    input  wbuf_entry_t       push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output wbuf_entry_t       head,
    output logic              empty,
    output logic              full
);

    wbuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer still takes a push when the head leaves at the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Entry storage.
    // NOTE: data storage has no reset; count gates visibility, so stale entries are never observed.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the WB stage and the
// multi-cycle unit, tracks in-flight destinations and raises decode stalls.
module rf_write_arbiter
    import rf_arb_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WB_RegWrite,
    input  logic [ADDR_W-1:0] WB_WN,
    input  logic [REG_W-1:0]  WB_WD,
    input  logic              MC_Valid,
    input  logic [ADDR_W-1:0] MC_WN,
    input  logic [REG_W-1:0]  MC_WD,
    output logic              MC_Ready,
    input  logic              Issue_Valid,
    input  logic [ADDR_W-1:0] Issue_WN,
    input  logic [ADDR_W-1:0] RN1,
    input  logic [ADDR_W-1:0] RN2,
    input  logic [ADDR_W-1:0] DN,
    output logic              Stall,
    output logic              RF_RegWrite,
    output logic [ADDR_W-1:0] RF_WN,
    output logic [REG_W-1:0]  RF_WD,
    output logic [PEND_W-1:0] Pending
);

    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    logic              wb_grant;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    wbuf_entry_t       head;
    wbuf_entry_t       push_data;
    logic              buf_empty;
    logic              buf_full;
    logic              hazard;
    logic [PEND_W-1:0] set_mask;
    logic [PEND_W-1:0] clr_mask;
    logic [PEND_W-1:0] src_mask;
    arb_state_e        state;
    arb_state_e        state_next;
    logic [AGE_W-1:0]  age;
    logic [AGE_W-1:0]  age_next;
    logic [AGE_W-1:0]  age_inc;

    // A WB write to r0 is a no-op, so it does not claim the port.
    assign wb_grant  = WB_RegWrite && (WB_WN != '0);
    assign pop       = !wb_grant && !buf_empty;
    assign MC_Ready  = Rst_n && !buf_full;
    assign push      = MC_Valid && MC_Ready;
    assign push_data = '{wn: MC_WN, wd: MC_WD};

    rf_wbuf u_wbuf (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    // Write-port mux: WB first, then the buffer head, otherwise idle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        RF_RegWrite = 1'b0;
        RF_WN       = '0;
        RF_WD       = '0;
        if (wb_grant) begin
            RF_RegWrite = 1'b1;
            RF_WN       = WB_WN;
            RF_WD       = WB_WD;
        end else if (!buf_empty) begin
            RF_RegWrite = 1'b1;
            RF_WN       = head.wn;
            RF_WD       = head.wd;
        end
    end

    // Scoreboard update masks; a same-cycle set overrides the clear.
    always_comb begin
        set_mask = Issue_Valid ? reg_bit(Issue_WN) : '0;
        clr_mask = pop ? reg_bit(head.wn) : '0;
        src_mask = reg_bit(RN1) | reg_bit(RN2) | reg_bit(DN);
    end

    // In-flight destination scoreboard.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Pending <= '0;
        end else begin
            Pending <= (Pending & ~clr_mask) | set_mask;
        end
    end

    // Decode stall on a hazard or while a starved head forces a bubble.
    always_comb begin
        hazard = |(Pending & src_mask);
        Stall  = hazard || (state == FORCE);
    end

    // Starvation tracker: age of the buffer head, saturating at AGE_MAX.
    always_comb begin
        state_next = state;
        age_next   = age;
        age_inc    = (age == AGE_LIM) ? age : age + AGE_W'(1);
        case (state)
            IDLE: begin
                age_next = '0;
                if (push) begin
                    state_next = PEND;
                end
            end
            PEND, FORCE: begin
                if (pop) begin
                    age_next   = '0;
                    state_next = (count == CNT_W'(1) && !push) ? IDLE : PEND;
                end else begin
                    age_next = age_inc;
                    if (age_inc == AGE_LIM) begin
                        state_next = FORCE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                age_next   = '0;
            end
        endcase
    end

    // Starvation state registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            age   <= '0;
        end else begin
            state <= state_next;
            age   <= age_next;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int AGE_LIMIT = 3;
    localparam int BUF_SLOTS = 2;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_wn;
    logic [31:0] wb_wd;
    logic        mc_valid;
    logic [4:0]  mc_wn;
    logic [31:0] mc_wd;
    logic        mc_ready;
    logic        issue_valid;
    logic [4:0]  issue_wn;
    logic [4:0]  rn1;
    logic [4:0]  rn2;
    logic [4:0]  dn;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_wd;
    logic [30:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  wn;
        logic [31:0] wd;
    } ent_t;

    ent_t q[$];
    bit   pend[32];
    int   waited;
    bit   last_push;
    bit   obs_hs;

    rf_write_arbiter dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .WB_RegWrite (wb_we),
        .WB_WN       (wb_wn),
        .WB_WD       (wb_wd),
        .MC_Valid    (mc_valid),
        .MC_WN       (mc_wn),
        .MC_WD       (mc_wd),
        .MC_Ready    (mc_ready),
        .Issue_Valid (issue_valid),
        .Issue_WN    (issue_wn),
        .RN1         (rn1),
        .RN2         (rn2),
        .DN          (dn),
        .Stall       (stall),
        .RF_RegWrite (rf_we),
        .RF_WN       (rf_wn),
        .RF_WD       (rf_wd),
        .Pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] model_pending();
        logic [30:0] v = '0;
        for (int i = 1; i < 32; i++) v[i-1] = pend[i];
        return v;
    endfunction

    function automatic bit model_hazard(input logic [4:0] r);
        return (r != 0) && pend[r];
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        waited    = 0;
        last_push = 0;
    endtask

    // Compare every output against the model for the current cycle's inputs.
    task automatic check_outputs();
        bit          g;
        logic        e_we;
        logic [4:0]  e_wn;
        logic [31:0] e_wd;
        bit          e_stall;
        g    = wb_we && (wb_wn != 0);
        e_we = 0; e_wn = 0; e_wd = 0;
        if (g) begin
            e_we = 1; e_wn = wb_wn; e_wd = wb_wd;
        end else if (q.size() > 0) begin
            e_we = 1; e_wn = q[0].wn; e_wd = q[0].wd;
        end
        e_stall = (waited >= AGE_LIMIT) || model_hazard(rn1) || model_hazard(rn2) || model_hazard(dn);
        check("rf_we",    rf_we,    e_we);
        check("rf_wn",    rf_wn,    e_wn);
        check("rf_wd",    rf_wd,    e_wd);
        check("mc_ready", mc_ready, q.size() < BUF_SLOTS);
        check("stall",    stall,    e_stall);
        check("pending",  pending,  model_pending());
        check("count",    dut.count, q.size());
    endtask

    // Advance the model across one clock edge using this cycle's inputs.
    task automatic model_edge();
        bit g;
        bit drain;
        bit push;
        g     = wb_we && (wb_wn != 0);
        drain = !g && (q.size() > 0);
        push  = mc_valid && (q.size() < BUF_SLOTS);
        if (q.size() > 0 && !drain) waited = (waited < AGE_LIMIT) ? waited + 1 : AGE_LIMIT;
        if (drain) begin
            if (q[0].wn != 0) pend[q[0].wn] = 0;
            void'(q.pop_front());
            waited = 0;
        end
        if (push) q.push_back('{wn: mc_wn, wd: mc_wd});
        if (issue_valid && issue_wn != 0) pend[issue_wn] = 1;
        if (q.size() == 0) waited = 0;
        last_push = push;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        obs_hs = mc_valid && mc_ready;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_wn = 0; wb_wd = 0;
        mc_valid = 0; mc_wn = 0; mc_wd = 0;
        issue_valid = 0; issue_wn = 0;
        rn1 = 0; rn2 = 0; dn = 0;
    endtask

    // Hold the current MC result until the DUT accepts it, within a bound.
    task automatic mc_wait_accept(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!obs_hs && n < budget);
        check("mc_accept_in_budget", obs_hs, 1'b1);
        mc_valid = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;

        // Reset values while reset is held.
        #12;
        check("rst_mc_ready", mc_ready, 1'b0);
        check("rst_stall",    stall,    1'b0);
        check("rst_rf_we",    rf_we,    1'b0);
        check("rst_pending",  pending,  31'h0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // MC result r5 with no WB traffic drains in the next cycle.
        mc_valid = 1; mc_wn = 5; mc_wd = 32'h1234;
        cycle();
        mc_valid = 0;
        settle();
        check("t1_rf_we", rf_we, 1'b1);
        check("t1_rf_wn", rf_wn, 5'd5);
        check("t1_rf_wd", rf_wd, 32'h1234);
        cycle();
        cycle();

        // Issue to r7, dependent decode stalls until the r7 result drains.
        issue_valid = 1; issue_wn = 7;
        cycle();
        issue_valid = 0; issue_wn = 0; rn1 = 7;
        settle();
        check("t2_stall_on", stall, 1'b1);
        check("t2_pend7",    pending[6], 1'b1);
        cycle();
        cycle();
        mc_valid = 1; mc_wn = 7; mc_wd = 32'hCAFE_0007;
        cycle();
        mc_valid = 0;
        settle();
        check("t2_stall_held", stall, 1'b1);
        cycle();
        settle();
        check("t2_pend7_clr", pending[6], 1'b0);
        check("t2_stall_off", stall, 1'b0);
        cycle();
        rn1 = 0;

        // Continuous WB starves buffered r3 until a bubble is forced.
        wb_we = 1; wb_wn = 10; wb_wd = 32'hAAAA_0000;
        mc_valid = 1; mc_wn = 3; mc_wd = 32'h0000_0333;
        cycle();
        mc_valid = 0;
        for (int i = 0; i < 2; i++) begin
            wb_wd = wb_wd + 1;
            cycle();
        end
        settle();
        check("t3_no_force_yet", stall, 1'b0);
        cycle();
        settle();
        check("t3_force_stall", stall, 1'b1);
        check("t3_force_state", dut.state, 2'd2);
        for (int i = 0; i < 6; i++) begin
            wb_wd = wb_wd + 1;
            cycle();
        end
        wb_we = 0;
        settle();
        check("t3_r3_write_wn", rf_wn, 5'd3);
        cycle();
        settle();
        check("t3_stall_clear", stall, 1'b0);
        cycle();

        // Two pushes under continuous WB fill the buffer; the third waits.
        wb_we = 1; wb_wn = 12; wb_wd = 32'h5555_0000;
        mc_valid = 1; mc_wn = 11; mc_wd = 32'h1111_1111;
        cycle();
        mc_wn = 13; mc_wd = 32'h1313_1313;
        cycle();
        mc_wn = 14; mc_wd = 32'h1414_1414;
        settle();
        check("t4_full_count", dut.count, 2'd2);
        check("t4_full_ready", mc_ready, 1'b0);
        cycle();
        cycle();
        wb_we = 0;
        mc_wait_accept(8);
        for (int i = 0; i < 4; i++) cycle();

        // Issue to r9 while a buffered r9 drains: the set wins.
        mc_valid = 1; mc_wn = 9; mc_wd = 32'h9999_9999;
        cycle();
        mc_valid = 0;
        issue_valid = 1; issue_wn = 9;
        cycle();
        issue_valid = 0; issue_wn = 0;
        settle();
        check("t5_pend9_kept", pending[8], 1'b1);
        wb_we = 1; wb_wn = 0; wb_wd = 32'hDEAD_BEEF;
        issue_valid = 1; issue_wn = 0;
        settle();
        check("t5_wb_r0_nowrite", rf_we, 1'b0);
        cycle();
        idle_inputs();
        settle();
        check("t5_issue_r0_ignored", pending, 31'h0000_0100);
        cycle();

        // Reset mid-operation with a full buffer and live scoreboard bits.
        issue_valid = 1; issue_wn = 20;
        wb_we = 1; wb_wn = 2; wb_wd = 32'h2222_2222;
        mc_valid = 1; mc_wn = 21; mc_wd = 32'h2121_2121;
        cycle();
        issue_valid = 0; issue_wn = 0;
        mc_wn = 22; mc_wd = 32'h2222_0022;
        cycle();
        idle_inputs();
        wb_we = 1; wb_wn = 2;
        settle();
        check("t6_pre_count", dut.count, 2'd2);
        #2;
        rst_n = 0;
        wb_we = 0; wb_wn = 0;
        #1;
        model_reset();
        check("t6_rst_count",   dut.count, 2'd0);
        check("t6_rst_pending", pending, 31'h0);
        check("t6_rst_stall",   stall, 1'b0);
        check("t6_rst_ready",   mc_ready, 1'b0);
        check("t6_rst_rf_we",   rf_we, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1;
        settle();
        check("t6_post_rf_we", rf_we, 1'b0);
        cycle();
        cycle();

        // Random traffic against the model; MC holds its result until accepted.
        for (int i = 0; i < 500; i++) begin
            if (last_push) mc_valid = 0;
            if (!mc_valid && ($urandom_range(2, 0) == 0)) begin
                mc_valid = 1;
                mc_wn    = 5'($urandom_range(31, 0));
                mc_wd    = $urandom;
            end
            wb_we       = ($urandom_range(9, 0) < 6);
            wb_wn       = 5'($urandom_range(31, 0));
            wb_wd       = $urandom;
            issue_valid = ($urandom_range(3, 0) == 0);
            issue_wn    = 5'($urandom_range(31, 0));
            rn1         = 5'($urandom_range(31, 0));
            rn2         = 5'($urandom_range(31, 0));
            dn          = ($urandom_range(1, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
